// File: rtl/countdown_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | countdown_sequencer: loads, prescales and stops an external down counter |
// | at a programmed terminal value, then idles or auto-reloads.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module countdown_sequencer #(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    input  logic                  repeat_en,
    input  logic [WIDTH-1:0]      target,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [WIDTH-1:0]      ctr_q,
    output logic                  ctr_set,
    output logic                  ctr_cnt,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            state
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]            r_state;
    logic [WIDTH-1:0]      r_tgt_lat;
    logic [PRESCALE_W-1:0] r_pre_lat;
    logic [PRESCALE_W-1:0] r_pre_cnt;

    logic w_at_target;
    logic w_pre_hit;

    assign w_at_target = (ctr_q == r_tgt_lat);
    assign w_pre_hit   = (r_pre_cnt == r_pre_lat);

    // The terminal check gates ctr_cnt so the counter can never step past target.
    assign ctr_set = (r_state == S_LOAD) && !stop;
    assign ctr_cnt = (r_state == S_RUN) && !stop && !w_at_target && !pause && w_pre_hit;
    assign done    = (r_state == S_DONE) && !stop;
    assign busy    = (r_state != S_IDLE);
    assign state   = r_state;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state   <= S_IDLE;
            r_tgt_lat <= '0;
            r_pre_lat <= '0;
            r_pre_cnt <= '0;
        end else if (stop && (r_state != S_IDLE)) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !stop) begin
                        r_tgt_lat <= target;
                        r_pre_lat <= prescale;
                        r_state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_pre_cnt <= '0;
                    r_state   <= S_RUN;
                end
                S_RUN: begin
                    if (w_at_target) begin
                        r_state <= S_DONE;
                    end else if (pause) begin
                        r_state <= S_HOLD;
                    end else if (w_pre_hit) begin
                        r_pre_cnt <= '0;
                    end else begin
                        r_pre_cnt <= r_pre_cnt + PRESCALE_W'(1);
                    end
                end
                // pre_cnt is left untouched so the prescale phase resumes where it stopped.
                S_HOLD: begin
                    if (!pause) begin
                        r_state <= S_RUN;
                    end
                end
                S_DONE: begin
                    r_state <= repeat_en ? S_LOAD : S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
